// File: rtl/n64_ctrl_responder.sv
`default_nettype none
// ============================================================================
// Module   : n64_ctrl_responder
// Brief    : N64 controller emulation on the joybus line; decodes console
//            commands and answers status/reset (0x00/0xFF) and read (0x01).
// Revision : 1.0 - initial release
// ============================================================================
module n64_ctrl_responder #(
  parameter int SAMPLE     = 8,
  parameter int TURNAROUND = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic        clk_4M,
  input  logic        rst,
  input  logic        din,
  output logic        dout,
  output logic        dout_en,
  input  logic [31:0] ctrl_state,
  output logic [7:0]  cmd_byte,
  output logic        cmd_valid,
  output logic        busy
);

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_RX_LOW  = 3'd1;
  localparam logic [2:0] c_RX_HIGH = 3'd2;
  localparam logic [2:0] c_RX_STOP = 3'd3;
  localparam logic [2:0] c_TURN    = 3'd4;
  localparam logic [2:0] c_TX_BIT  = 3'd5;
  localparam logic [2:0] c_TX_STOP = 3'd6;

  localparam logic [7:0]  c_SAMPLE    = 8'(SAMPLE);
  localparam logic [7:0]  c_TIMEOUT   = 8'(TIMEOUT);
  localparam logic [7:0]  c_TURN_LAST = 8'(TURNAROUND - 1);
  localparam logic [7:0]  c_BIT_LAST  = 8'd15;
  localparam logic [7:0]  c_STOP_LAST = 8'd7;
  localparam logic [7:0]  c_T0_LOW    = 8'd12;
  localparam logic [7:0]  c_T1_LOW    = 8'd4;
  localparam logic [31:0] c_STATUS_ID = {24'h050002, 8'h00};

  logic        r_din_meta;
  logic        r_din_sync;
  logic        r_din_prev;
  logic [2:0]  r_state;
  logic [7:0]  r_timer;
  logic [5:0]  r_bit_cnt;
  logic [7:0]  r_rx_shift;
  logic [31:0] r_tx_shift;
  logic [5:0]  r_tx_last;
  logic [7:0]  r_cmd_byte;
  logic        r_cmd_valid;
  logic        r_dout;
  logic        r_dout_en;

  logic [2:0]  w_state_nxt;
  logic [7:0]  w_timer_nxt;
  logic [5:0]  w_bit_cnt_nxt;
  logic [7:0]  w_rx_shift_nxt;
  logic [31:0] w_tx_shift_nxt;
  logic [5:0]  w_tx_last_nxt;
  logic [7:0]  w_cmd_byte_nxt;
  logic        w_cmd_valid_nxt;
  logic        w_dout_nxt;
  logic        w_dout_en_nxt;
  logic        w_fall;
  logic        w_known_cmd;

  // Our own transmission echoes back on din, so edges are ignored while driving.
  assign w_fall      = r_din_prev & ~r_din_sync & ~r_dout_en;
  assign w_known_cmd = (r_rx_shift == 8'h00) || (r_rx_shift == 8'hFF) ||
                       (r_rx_shift == 8'h01);

  always_comb begin
    w_state_nxt     = r_state;
    w_timer_nxt     = r_timer;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_rx_shift_nxt  = r_rx_shift;
    w_tx_shift_nxt  = r_tx_shift;
    w_tx_last_nxt   = r_tx_last;
    w_cmd_byte_nxt  = r_cmd_byte;
    w_cmd_valid_nxt = 1'b0;

    case (r_state)
      c_IDLE: begin
        if (w_fall) begin
          w_state_nxt   = c_RX_LOW;
          w_timer_nxt   = 8'd1;
          w_bit_cnt_nxt = 6'd0;
        end
      end
      c_RX_LOW: begin
        w_timer_nxt = r_timer + 8'd1;
        if (r_timer == c_SAMPLE) begin
          w_rx_shift_nxt = {r_rx_shift[6:0], r_din_sync};
          w_bit_cnt_nxt  = r_bit_cnt + 6'd1;
          w_state_nxt    = c_RX_HIGH;
        end else if (r_timer >= c_TIMEOUT) begin
          w_state_nxt = c_IDLE;
        end
      end
      c_RX_HIGH: begin
        w_timer_nxt = r_timer + 8'd1;
        if (w_fall) begin
          w_timer_nxt = 8'd1;
          w_state_nxt = (r_bit_cnt == 6'd8) ? c_RX_STOP : c_RX_LOW;
        end else if (r_timer >= c_TIMEOUT) begin
          w_state_nxt = c_IDLE;
        end
      end
      c_RX_STOP: begin
        w_timer_nxt = r_timer + 8'd1;
        if (r_din_sync) begin
          w_cmd_byte_nxt  = r_rx_shift;
          w_cmd_valid_nxt = 1'b1;
          w_timer_nxt     = 8'd0;
          w_state_nxt     = w_known_cmd ? c_TURN : c_IDLE;
        end else if (r_timer >= c_TIMEOUT) begin
          w_state_nxt = c_IDLE;
        end
      end
      c_TURN: begin
        if (w_fall) begin
          w_state_nxt = c_IDLE;
        end else if (!r_din_sync) begin
          w_timer_nxt = 8'd0;
        end else if (r_timer == c_TURN_LAST) begin
          // Reply is frozen here; later ctrl_state changes belong to the next poll.
          w_state_nxt   = c_TX_BIT;
          w_timer_nxt   = 8'd0;
          w_bit_cnt_nxt = 6'd0;
          if (r_cmd_byte == 8'h01) begin
            w_tx_shift_nxt = ctrl_state;
            w_tx_last_nxt  = 6'd31;
          end else begin
            w_tx_shift_nxt = c_STATUS_ID;
            w_tx_last_nxt  = 6'd23;
          end
        end else begin
          w_timer_nxt = r_timer + 8'd1;
        end
      end
      c_TX_BIT: begin
        w_timer_nxt = r_timer + 8'd1;
        if (r_timer == c_BIT_LAST) begin
          w_timer_nxt    = 8'd0;
          w_tx_shift_nxt = {r_tx_shift[30:0], 1'b0};
          if (r_bit_cnt == r_tx_last) begin
            w_state_nxt = c_TX_STOP;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 6'd1;
          end
        end
      end
      c_TX_STOP: begin
        w_timer_nxt = r_timer + 8'd1;
        if (r_timer == c_STOP_LAST) begin
          w_timer_nxt = 8'd0;
          w_state_nxt = c_IDLE;
        end
      end
      default: begin
        w_state_nxt = c_IDLE;
      end
    endcase

    // Pad drive is computed from next-state values so dout/dout_en come straight off flops.
    w_dout_en_nxt = (w_state_nxt == c_TX_BIT) || (w_state_nxt == c_TX_STOP);
    w_dout_nxt    = 1'b1;
    if (w_state_nxt == c_TX_BIT) begin
      w_dout_nxt = (w_timer_nxt >= (w_tx_shift_nxt[31] ? c_T1_LOW : c_T0_LOW));
    end else if (w_state_nxt == c_TX_STOP) begin
      w_dout_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk_4M or posedge rst) begin
    if (rst) begin
      r_din_meta  <= 1'b1;
      r_din_sync  <= 1'b1;
      r_din_prev  <= 1'b1;
      r_state     <= c_IDLE;
      r_timer     <= 8'd0;
      r_bit_cnt   <= 6'd0;
      r_rx_shift  <= 8'h00;
      r_tx_shift  <= 32'h0;
      r_tx_last   <= 6'd0;
      r_cmd_byte  <= 8'h00;
      r_cmd_valid <= 1'b0;
      r_dout      <= 1'b1;
      r_dout_en   <= 1'b0;
    end else begin
      r_din_meta  <= din;
      r_din_sync  <= r_din_meta;
      r_din_prev  <= r_din_sync;
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_rx_shift  <= w_rx_shift_nxt;
      r_tx_shift  <= w_tx_shift_nxt;
      r_tx_last   <= w_tx_last_nxt;
      r_cmd_byte  <= w_cmd_byte_nxt;
      r_cmd_valid <= w_cmd_valid_nxt;
      r_dout      <= w_dout_nxt;
      r_dout_en   <= w_dout_en_nxt;
    end
  end

  assign dout      = r_dout;
  assign dout_en   = r_dout_en;
  assign cmd_byte  = r_cmd_byte;
  assign cmd_valid = r_cmd_valid;
  assign busy      = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_n64_ctrl_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_n64_ctrl_responder
// Brief    : Directed bench: console model on the shared line plus a reply decoder.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_n64_ctrl_responder;

  logic        clk_4M;
  logic        rst;
  logic        din;
  logic        dout;
  logic        dout_en;
  logic [31:0] ctrl_state;
  logic [7:0]  cmd_byte;
  logic        cmd_valid;
  logic        busy;
  logic        con;

  int n_checks = 0;
  int n_errors = 0;

  n64_ctrl_responder dut (
    .clk_4M     (clk_4M),
    .rst        (rst),
    .din        (din),
    .dout       (dout),
    .dout_en    (dout_en),
    .ctrl_state (ctrl_state),
    .cmd_byte   (cmd_byte),
    .cmd_valid  (cmd_valid),
    .busy       (busy)
  );

  // Shared line: controller drives when enabled, otherwise console (1 = released to pull-up).
  assign din = dout_en ? dout : con;

  initial clk_4M = 1'b0;
  always #5 clk_4M = ~clk_4M;

  // Reply decoder and event monitor
  logic        prev_en   = 1'b0;
  int          valid_cnt = 0;
  logic [7:0]  last_cmd  = 8'h00;
  int          since_valid = 0;
  int          last_gap  = 0;
  int          en_cnt    = 0;
  int          low_run   = 0;
  logic [31:0] word      = 32'h0;
  int          nbits     = 0;
  int          frames    = 0;
  int          last_len  = 0;
  int          last_stop = 0;
  logic [31:0] last_word = 32'h0;
  int          last_bits = 0;

  always @(negedge clk_4M) begin
    prev_en <= dout_en;
    if (cmd_valid) begin
      valid_cnt   <= valid_cnt + 1;
      last_cmd    <= cmd_byte;
      since_valid <= 0;
    end else begin
      since_valid <= since_valid + 1;
    end
    if (dout_en) begin
      en_cnt <= en_cnt + 1;
      if (!prev_en) last_gap <= since_valid + 1;
      if (!dout) begin
        low_run <= low_run + 1;
      end else if (low_run != 0) begin
        word    <= {word[30:0], (low_run < 8)};
        nbits   <= nbits + 1;
        low_run <= 0;
      end
    end else if (prev_en) begin
      frames    <= frames + 1;
      last_len  <= en_cnt;
      last_stop <= low_run;
      last_word <= word;
      last_bits <= nbits;
      en_cnt    <= 0;
      low_run   <= 0;
      word      <= 32'h0;
      nbits     <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_4M);
    #1;
  endtask

  task automatic send_bit(input logic b);
    con = 1'b0;
    tick(b ? 4 : 12);
    con = 1'b1;
    tick(b ? 12 : 4);
  endtask

  task automatic send_cmd(input logic [7:0] c);
    for (int i = 7; i >= 0; i--) send_bit(c[i]);
    con = 1'b0;
    tick(4);
    con = 1'b1;
    tick(4);
  endtask

  task automatic wait_frame(input string tag);
    int start;
    bit done;
    start = frames;
    done  = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      tick(1);
      if (frames != start) done = 1'b1;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic wait_en(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick(1);
      if (dout_en) seen = 1'b1;
    end
    check({tag, "_en_rise"}, 32'(seen), 32'd1);
  endtask

  initial begin
    int vc0;
    int fr0;
    rst        = 1'b1;
    con        = 1'b1;
    ctrl_state = 32'h0;
    tick(3);
    check("rst_dout",      32'(dout),      32'd1);
    check("rst_dout_en",   32'(dout_en),   32'd0);
    check("rst_cmd_byte",  32'(cmd_byte),  32'h00);
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    rst = 1'b0;
    tick(5);

    // Read command
    ctrl_state = 32'h8000_1234;
    vc0 = valid_cnt;
    send_cmd(8'h01);
    wait_frame("rd");
    check("rd_nvalid", 32'(valid_cnt), 32'(vc0 + 1));
    check("rd_cmd",    32'(last_cmd),  32'h01);
    check("rd_gap",    32'(last_gap),  32'd8);
    check("rd_len",    32'(last_len),  32'd520);
    check("rd_word",   last_word,      32'h8000_1234);
    check("rd_bits",   32'(last_bits), 32'd32);
    check("rd_stop",   32'(last_stop), 32'd8);
    tick(10);

    // Status and reset commands
    send_cmd(8'h00);
    wait_frame("st00");
    check("st00_cmd",  32'(last_cmd),  32'h00);
    check("st00_len",  32'(last_len),  32'd392);
    check("st00_word", last_word,      32'h0005_0002);
    check("st00_bits", 32'(last_bits), 32'd24);
    tick(10);
    send_cmd(8'hFF);
    wait_frame("stff");
    check("stff_cmd",  32'(last_cmd),  32'hFF);
    check("stff_len",  32'(last_len),  32'd392);
    check("stff_word", last_word,      32'h0005_0002);
    tick(10);

    // Unknown command: decoded, no reply
    vc0 = valid_cnt;
    fr0 = frames;
    send_cmd(8'h02);
    check("unk_busy",   32'(busy),      32'd0);
    check("unk_nvalid", 32'(valid_cnt), 32'(vc0 + 1));
    check("unk_cmd",    32'(last_cmd),  32'h02);
    tick(100);
    check("unk_frames", 32'(frames),    32'(fr0));

    // Truncated command then timeout
    vc0 = valid_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    tick(24);
    check("to_busy_mid",  32'(busy),      32'd1);
    tick(40);
    check("to_busy_end",  32'(busy),      32'd0);
    check("to_nvalid",    32'(valid_cnt), 32'(vc0));
    check("to_cmd_byte",  32'(cmd_byte),  32'h02);
    ctrl_state = 32'h0000_00A5;
    send_cmd(8'h01);
    wait_frame("to_rd");
    check("to_rd_word", last_word,     32'h0000_00A5);
    check("to_rd_len",  32'(last_len), 32'd520);
    tick(10);

    // ctrl_state change during transmission
    ctrl_state = 32'hFFFF_0000;
    send_cmd(8'h01);
    wait_en("chg");
    tick(50);
    ctrl_state = 32'h0000_0000;
    wait_frame("chg");
    check("chg_word", last_word,     32'hFFFF_0000);
    check("chg_len",  32'(last_len), 32'd520);
    tick(10);

    // Reset in the middle of a reply
    ctrl_state = 32'h1234_5678;
    send_cmd(8'h01);
    wait_en("mrst");
    tick(100);
    rst = 1'b1;
    #1;
    check("mrst_dout_en",  32'(dout_en),  32'd0);
    check("mrst_busy",     32'(busy),     32'd0);
    check("mrst_cmd_byte", 32'(cmd_byte), 32'h00);
    tick(3);
    rst = 1'b0;
    tick(5);
    ctrl_state = 32'h0F0F_00FF;
    send_cmd(8'h01);
    wait_frame("post");
    check("post_word", last_word,     32'h0F0F_00FF);
    check("post_len",  32'(last_len), 32'd520);
    check("post_cmd",  32'(last_cmd), 32'h01);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
